// File: rtl/sum_acc_pkg.sv
// sum_acc_pkg: shared types and default sizing for the sum accumulator.
//   sum_acc_state_t : FSM state (ACC collecting samples, HOLD presenting a total)
//   DEF_SUM_W/DEF_ACC_W/DEF_COUNT : default incoming width, result width, block size
package sum_acc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } sum_acc_state_t;

    localparam int DEF_SUM_W = 5;
    localparam int DEF_ACC_W = 7;
    localparam int DEF_COUNT = 8;

endpackage

// File: rtl/sum_acc_if.sv
// sum_acc_if: input stream (sum from the adder) and output block handshake.
//   in_valid/in_ready/sum_in      : sample stream into the accumulator
//   out_valid/out_ready/acc_out/ovf : completed block toward the next stage
//   modport slave  : accumulator view
//   modport master : producer/consumer view (testbench, surrounding datapath)
interface sum_acc_if #(
    parameter int SUM_W = 5,
    parameter int ACC_W = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] sum_in;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;

    modport slave (
        input  in_valid, sum_in, out_ready,
        output in_ready, out_valid, acc_out, ovf
    );

    modport master (
        output in_valid, sum_in, out_ready,
        input  in_ready, out_valid, acc_out, ovf
    );
endinterface

// File: rtl/sum_acc_add.sv
// sum_acc_add: combinational ACC_W+1-bit add of the running total and a sample.
//   acc    : current running total
//   sum_in : incoming unsigned sample, zero-extended
//   res    : next running total (wrapped, or clamped when SUM_ACC_SAT_EN is defined)
//   carry  : carry into bit ACC_W, i.e. this add overflowed ACC_W bits
// Build option: SUM_ACC_SAT_EN selects saturation instead of modulo wrap.
module sum_acc_add #(
    parameter int SUM_W = 5,
    parameter int ACC_W = 7
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [SUM_W-1:0] sum_in,
    output logic [ACC_W-1:0] res,
    output logic             carry
);
    logic [ACC_W:0] full;

    assign full  = {1'b0, acc} + (ACC_W+1)'(sum_in);
    assign carry = full[ACC_W];

`ifdef SUM_ACC_SAT_EN
    // Once clamped at all-ones, any nonzero sample carries again and a zero
    // sample leaves it unchanged, so the clamp persists for the whole block.
    assign res = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    assign res = full[ACC_W-1:0];
`endif
endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates COUNT sums per block and holds the block total
// with a sticky overflow flag until downstream takes it.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, discards any partial block
//   bus : sum_acc_if slave (in_valid/in_ready/sum_in, out_valid/out_ready/acc_out/ovf)
// Build option: SUM_ACC_SAT_EN (handled in sum_acc_add) saturates instead of wrapping.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int SUM_W = DEF_SUM_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int COUNT = DEF_COUNT
) (
    input logic     clk,
    input logic     rst,
    sum_acc_if.slave bus
);
    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    sum_acc_state_t   state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_blk;      // overflow seen earlier in this block
    logic [ACC_W-1:0] acc_out_q;
    logic             ovf_q;
    logic [ACC_W-1:0] add_res;
    logic             add_carry;
    logic             in_ready, out_valid;
    logic             accept, done, release_blk;

    sum_acc_add #(.SUM_W(SUM_W), .ACC_W(ACC_W)) u_add (
        .acc    (acc),
        .sum_in (bus.sum_in),
        .res    (add_res),
        .carry  (add_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACC;
        else     state <= state_nxt;
    end

    // Handshake outputs depend on state only; in_valid/out_ready only steer
    // the next state and the register enables.
    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        accept      = 1'b0;
        done        = 1'b0;
        release_blk = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                accept   = bus.in_valid;
                done     = accept && (cnt == LAST);
                if (done) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid   = 1'b1;
                release_blk = bus.out_ready;
                if (release_blk) state_nxt = ACC;
            end
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            ovf_blk   <= 1'b0;
            acc_out_q <= '0;
            ovf_q     <= 1'b0;
        end else if (done) begin
            acc       <= add_res;
            cnt       <= cnt + CNT_W'(1);
            ovf_blk   <= ovf_blk | add_carry;
            acc_out_q <= add_res;
            ovf_q     <= ovf_blk | add_carry;
        end else if (accept) begin
            acc     <= add_res;
            cnt     <= cnt + CNT_W'(1);
            ovf_blk <= ovf_blk | add_carry;
        end else if (release_blk) begin
            // acc_out keeps the last total; only the sticky flag is dropped.
            acc     <= '0;
            cnt     <= '0;
            ovf_blk <= 1'b0;
            ovf_q   <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.acc_out   = acc_out_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed stimulus pushes expected block totals into a
// queue; a monitor pops and compares on every out_valid/out_ready handshake.
module tb_sum_accumulator;
    typedef struct {
        logic [6:0] acc;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;
    exp_t q[$];

    sum_acc_if #(.SUM_W(5), .ACC_W(7)) bus ();

    sum_accumulator #(.SUM_W(5), .ACC_W(7), .COUNT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic exp_t mk(input int a, input bit o);
        exp_t e;
        e.acc = 7'(a);
        e.ovf = o;
        return e;
    endfunction

    // Scoreboard monitor: a handshake happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_block", 32'(bus.acc_out), 32'hFFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("blk_acc", 32'(bus.acc_out), 32'(e.acc));
                chk("blk_ovf", 32'(bus.ovf), 32'(e.ovf));
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic accept_one(input logic [4:0] s);
        bit rdy;
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.sum_in   = s;
        for (int i = 0; i < 20; i++) begin
            rdy = bus.in_ready;
            @(posedge clk); #1;
            if (rdy) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_block(input logic [4:0] s, input int n);
        for (int i = 0; i < n; i++) accept_one(s);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.in_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.sum_in    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_acc_out", 32'(bus.acc_out), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 8 x 3 with out_ready high: one-cycle out_valid pulse.
        bus.out_ready = 1'b1;
        q.push_back(mk(24, 0));
        send_block(5'd3, 8);
        chk("t1_out_valid_hi", 32'(bus.out_valid), 1);
        chk("t1_in_ready_lo", 32'(bus.in_ready), 0);
        @(posedge clk); #1;
        chk("t1_out_valid_lo", 32'(bus.out_valid), 0);
        chk("t1_in_ready_hi", 32'(bus.in_ready), 1);

        // 8 x 31 = 248 overflows 7 bits.
        wait_idle();
`ifdef SUM_ACC_SAT_EN
        q.push_back(mk(127, 1));
`else
        q.push_back(mk(120, 1));
`endif
        send_block(5'd31, 8);

        // Held block while input keeps pushing; then release and 8 x 1.
        wait_idle();
        bus.out_ready = 1'b0;
        q.push_back(mk(72, 0));
        send_block(5'd9, 8);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.sum_in   = 5'd9;
            chk("t3_in_ready_hold", 32'(bus.in_ready), 0);
            chk("t3_out_valid_hold", 32'(bus.out_valid), 1);
            chk("t3_acc_stable", 32'(bus.acc_out), 72);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3_released", 32'(bus.out_valid), 0);
        q.push_back(mk(8, 0));
        send_block(5'd1, 8);

        // in_valid toggling each cycle: 8 accepts over 16 cycles.
        wait_idle();
        q.push_back(mk(16, 0));
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = ((i % 2) == 0);
            bus.sum_in   = 5'd2;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;

        // Reset mid-block discards the partial sum.
        wait_idle();
        send_block(5'd5, 3);
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_in_ready", 32'(bus.in_ready), 1);
        chk("t5_rst_out_valid", 32'(bus.out_valid), 0);
        chk("t5_rst_acc_out", 32'(bus.acc_out), 0);
        chk("t5_rst_ovf", 32'(bus.ovf), 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        q.push_back(mk(32, 0));
        send_block(5'd4, 8);

        // Back-to-back blocks: ovf must clear between them.
        wait_idle();
        q.push_back(mk(80, 0));
        send_block(5'd10, 8);
`ifdef SUM_ACC_SAT_EN
        q.push_back(mk(127, 1));
`else
        q.push_back(mk(32, 1));
`endif
        send_block(5'd20, 8);

        for (int i = 0; i < 10; i++) begin
            if (q.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("queue_drain", 32'(q.size()), 0);
        chk("end_idle", 32'(bus.in_ready), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
